// File: rtl/cbus_ram_responder.sv
// Cache-bus memory responder: answers cbus_req_t transactions from a small word array.
// Optional random back-pressure in BURST is enabled by defining CBUS_RAM_RANDOM_STALL_EN.
package cbus_pkg;
    typedef struct packed {
        logic        valid;
        logic        is_write;
        logic [2:0]  size;
        logic [31:0] addr;
        logic [3:0]  strobe;
        logic [31:0] data;
        logic [3:0]  len;
        logic [1:0]  burst;
    } cbus_req_t;

    typedef struct packed {
        logic        ready;
        logic        last;
        logic [31:0] data;
    } cbus_resp_t;

    localparam logic [1:0] CBUS_BURST_FIXED = 2'b00;
    localparam logic [1:0] CBUS_BURST_INCR  = 2'b01;
endpackage

module cbus_ram_responder
    import cbus_pkg::*;
#(
    parameter int WORDS   = 16,
    parameter int LATENCY = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  cbus_req_t             creq,
    output cbus_resp_t            cresp,
    output logic [WORDS*32-1:0]   mem
);
    localparam int AW = $clog2(WORDS);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WAIT  = 2'd1,
        S_BURST = 2'd2
    } state_t;

    state_t        state_q;
    logic [3:0]    beat_q;
    logic [3:0]    lat_q;
    logic [3:0]    len_q;
    logic [AW-1:0] base_q;
    logic          incr_q;
    logic          wr_q;
    logic [31:0]   mem_q [WORDS];

    logic          stall;
    logic          beat_fire;
    logic          last_beat;
    logic [AW-1:0] idx;

    // Size, the sub-word offset and the address bits above the array are deliberately ignored.
    logic unused_ok;
    assign unused_ok = ^{creq.size, creq.addr[31:AW+2], creq.addr[1:0]};

`ifdef CBUS_RAM_RANDOM_STALL_EN
    logic [15:0] lfsr_q;

    // Fibonacci LFSR, taps 16,14,13,11; free-runs every cycle regardless of state.
    always_ff @(posedge clk) begin
        if (reset) begin
            lfsr_q <= 16'hACE1;
        end else begin
            lfsr_q <= {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
        end
    end

    assign stall = lfsr_q[0];
`else
    assign stall = 1'b0;
`endif

    assign idx       = incr_q ? (base_q + AW'(beat_q)) : base_q;
    assign beat_fire = (state_q == S_BURST) && !stall;
    assign last_beat = (beat_q == len_q);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            beat_q  <= '0;
            lat_q   <= '0;
            len_q   <= '0;
            base_q  <= '0;
            incr_q  <= 1'b0;
            wr_q    <= 1'b0;
            for (int i = 0; i < WORDS; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            if (beat_fire && wr_q) begin
                for (int j = 0; j < 4; j++) begin
                    if (creq.strobe[j]) begin
                        mem_q[idx][8*j +: 8] <= creq.data[8*j +: 8];
                    end
                end
            end

            case (state_q)
                S_IDLE: begin
                    if (creq.valid) begin
                        base_q <= creq.addr[2 +: AW];
                        len_q  <= creq.len;
                        incr_q <= (creq.burst == CBUS_BURST_INCR);
                        wr_q   <= creq.is_write;
                        beat_q <= '0;
                        if (LATENCY == 0) begin
                            state_q <= S_BURST;
                        end else begin
                            lat_q   <= 4'(LATENCY);
                            state_q <= S_WAIT;
                        end
                    end
                end
                S_WAIT: begin
                    lat_q <= lat_q - 4'd1;
                    if (lat_q <= 4'd1) begin
                        state_q <= S_BURST;
                    end
                end
                S_BURST: begin
                    if (beat_fire) begin
                        if (last_beat) begin
                            state_q <= S_IDLE;
                        end else begin
                            beat_q <= beat_q + 4'd1;
                        end
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // Read data is combinational so a write in one transaction is visible to the next without delay.
    always_comb begin
        cresp       = '0;
        cresp.ready = beat_fire;
        cresp.last  = beat_fire && last_beat;
        cresp.data  = beat_fire ? mem_q[idx] : 32'h0;
    end

    for (genvar g = 0; g < WORDS; g++) begin : g_mem_view
        assign mem[32*g +: 32] = mem_q[g];
    end
endmodule

// File: tb/tb_cbus_ram_responder.sv
// Directed bench for cbus_ram_responder (default build, WORDS=16, LATENCY=2).
module tb_cbus_ram_responder;
    import cbus_pkg::*;

    localparam int WORDS   = 16;
    localparam int LATENCY = 2;

    logic               clk;
    logic               reset;
    cbus_req_t          creq;
    cbus_resp_t         cresp;
    logic [WORDS*32-1:0] mem;

    int checks   = 0;
    int failures = 0;

    logic [31:0] wr_data  [16];
    logic [31:0] exp_data [16];

    cbus_ram_responder #(
        .WORDS   (WORDS),
        .LATENCY (LATENCY)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .creq  (creq),
        .cresp (cresp),
        .mem   (mem)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] word(input int i);
        return mem[32*i +: 32];
    endfunction

    // Issues one transaction in the current IDLE cycle and checks every cycle up to the
    // following IDLE cycle. When abort_at <= len, reset is raised during that beat instead.
    task automatic txn(input string name, input logic wr, input logic [31:0] addr,
                       input logic [3:0] len, input logic [1:0] burst,
                       input logic [3:0] strb, input int abort_at);
        creq          = '0;
        creq.valid    = 1'b1;
        creq.is_write = wr;
        creq.size     = 3'd2;
        creq.addr     = addr;
        creq.len      = len;
        creq.burst    = burst;
        creq.strobe   = strb;
        creq.data     = wr_data[0];
        chk({name, ":accept_ready"}, {31'b0, cresp.ready}, 32'd0);
        for (int c = 1; c <= LATENCY; c++) begin
            tick();
            chk($sformatf("%s:wait%0d_ready", name, c), {31'b0, cresp.ready}, 32'd0);
            chk($sformatf("%s:wait%0d_data", name, c), cresp.data, 32'd0);
        end
        for (int k = 0; k <= int'(len); k++) begin
            tick();
            creq.data = wr_data[k];
            chk($sformatf("%s:beat%0d_ready", name, k), {31'b0, cresp.ready}, 32'd1);
            chk($sformatf("%s:beat%0d_last", name, k), {31'b0, cresp.last},
                (k == int'(len)) ? 32'd1 : 32'd0);
            if (!wr) begin
                chk($sformatf("%s:beat%0d_data", name, k), cresp.data, exp_data[k]);
            end
            if (k == abort_at) begin
                reset = 1'b1;
                tick();
                reset = 1'b0;
                creq  = '0;
                chk({name, ":abort_ready"}, {31'b0, cresp.ready}, 32'd0);
                chk({name, ":abort_mem"}, {31'b0, (mem == '0)}, 32'd1);
                return;
            end
        end
        creq.valid = 1'b0;
        tick();
        chk({name, ":post_ready"}, {31'b0, cresp.ready}, 32'd0);
        chk({name, ":post_last"}, {31'b0, cresp.last}, 32'd0);
    endtask

    initial begin
        reset = 1'b1;
        creq  = '0;
        for (int i = 0; i < 16; i++) begin
            wr_data[i]  = '0;
            exp_data[i] = '0;
        end
        tick();
        tick();
        chk("reset_ready", {31'b0, cresp.ready}, 32'd0);
        chk("reset_last", {31'b0, cresp.last}, 32'd0);
        chk("reset_data", cresp.data, 32'd0);
        chk("reset_mem", {31'b0, (mem == '0)}, 32'd1);
        reset = 1'b0;
        tick();

        // Single read of a cleared word.
        exp_data[0] = 32'h0;
        txn("rd_8", 1'b0, 32'h8, 4'd0, CBUS_BURST_INCR, 4'h0, 16);

        // Full-word write then read-back.
        wr_data[0] = 32'hDEADBEEF;
        txn("wr_4", 1'b1, 32'h4, 4'd0, CBUS_BURST_INCR, 4'hF, 16);
        chk("mem_w1_full", word(1), 32'hDEADBEEF);
        exp_data[0] = 32'hDEADBEEF;
        txn("rd_4", 1'b0, 32'h4, 4'd0, CBUS_BURST_INCR, 4'h0, 16);

        // Byte-strobed write (bytes 0 and 2).
        wr_data[0] = 32'h11223344;
        txn("wr_4_part", 1'b1, 32'h4, 4'd0, CBUS_BURST_INCR, 4'b0101, 16);
        chk("mem_w1_part", word(1), 32'hDE22BE44);
        exp_data[0] = 32'hDE22BE44;
        txn("rd_4_part", 1'b0, 32'h4, 4'd0, CBUS_BURST_INCR, 4'h0, 16);

        // INCR burst wrapping from index 14 to 1.
        wr_data[0] = 32'd1; wr_data[1] = 32'd2; wr_data[2] = 32'd3; wr_data[3] = 32'd4;
        txn("wr_incr", 1'b1, 32'h38, 4'd3, CBUS_BURST_INCR, 4'hF, 16);
        chk("mem_w14", word(14), 32'd1);
        chk("mem_w15", word(15), 32'd2);
        chk("mem_w0", word(0), 32'd3);
        chk("mem_w1", word(1), 32'd4);
        exp_data[0] = 32'd1; exp_data[1] = 32'd2; exp_data[2] = 32'd3; exp_data[3] = 32'd4;
        txn("rd_incr", 1'b0, 32'h38, 4'd3, CBUS_BURST_INCR, 4'h0, 16);

        // FIXED read repeats one word.
        wr_data[0] = 32'hA5A55A5A;
        txn("wr_5", 1'b1, 32'h14, 4'd0, CBUS_BURST_INCR, 4'hF, 16);
        for (int i = 0; i < 4; i++) exp_data[i] = 32'hA5A55A5A;
        txn("rd_fixed", 1'b0, 32'h14, 4'd3, CBUS_BURST_FIXED, 4'h0, 16);

        // FIXED write: last beat wins, neighbour untouched.
        wr_data[0] = 32'h11111111; wr_data[1] = 32'h22222222;
        txn("wr_fixed", 1'b1, 32'h20, 4'd1, CBUS_BURST_FIXED, 4'hF, 16);
        chk("mem_w8", word(8), 32'h22222222);
        chk("mem_w9", word(9), 32'h0);

        // Upper and low address bits ignored: 0xFFFFFF17 selects index 5.
        exp_data[0] = 32'hA5A55A5A;
        txn("rd_alias", 1'b0, 32'hFFFFFF17, 4'd0, CBUS_BURST_INCR, 4'h0, 16);

        // Reset during beat 2 of an INCR write aborts and clears storage.
        for (int i = 0; i < 4; i++) wr_data[i] = 32'h99999999;
        txn("wr_abort", 1'b1, 32'h0, 4'd3, CBUS_BURST_INCR, 4'hF, 2);

        // Responder is usable immediately after the aborted transaction.
        wr_data[0] = 32'h0BADF00D;
        txn("wr_after", 1'b1, 32'h3C, 4'd0, CBUS_BURST_INCR, 4'hF, 16);
        exp_data[0] = 32'h0BADF00D;
        txn("rd_after", 1'b0, 32'h3C, 4'd0, CBUS_BURST_INCR, 4'h0, 16);
        chk("mem_w15_after", word(15), 32'h0BADF00D);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
